// File: rtl/huffman_pkg.sv
// Shared constants and FSM state encoding for the canonical Huffman encoder/decoder pair.
package huffman_pkg;
  localparam int HUF_MAX_LEN = 15;
  localparam int LEN_W       = 4;
  localparam int CNT_W       = 9;
  localparam int IDX_W       = 9;
  localparam int SYM_AW      = 8;
  localparam int TOT_W       = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DECODE,
    ST_EMIT,
    ST_DONE,
    ST_ERROR
  } huf_state_t;
endpackage

// File: rtl/huffman_decoder_if.sv
// Bit-stream input and decoded-symbol output handshakes of the Huffman decoder.
interface huffman_decoder_if #(parameter int BIT_WIDTH = 8);
  logic                 bit_valid_i;
  logic                 bit_i;
  logic                 last_i;
  logic                 bit_ready_o;
  logic                 sym_valid_o;
  logic [BIT_WIDTH-1:0] sym_o;
  logic                 sym_ready_i;

  modport master (
    output bit_valid_i, bit_i, last_i, sym_ready_i,
    input  bit_ready_o, sym_valid_o, sym_o
  );

  modport slave (
    input  bit_valid_i, bit_i, last_i, sym_ready_i,
    output bit_ready_o, sym_valid_o, sym_o
  );
endinterface

// File: rtl/huffman_canon_table.sv
// Per-length code counts, canonical first_code/first_idx built one length per cycle,
// and a combinational match/offset lookup for the candidate codeword.
module huffman_canon_table
  import huffman_pkg::*;
#(
  parameter int MAX_LEN = HUF_MAX_LEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cnt_we,
  input  logic [LEN_W-1:0] cnt_addr,
  input  logic [CNT_W-1:0] cnt_data,
  input  logic             prep_init,
  input  logic             prep_step,
  output logic             prep_last,
  input  logic [MAX_LEN:0] acc,
  input  logic [LEN_W-1:0] len,
  output logic             match,
  output logic [IDX_W-1:0] idx
);
  localparam int CW = MAX_LEN + 1;

  logic [CNT_W-1:0] count      [0:MAX_LEN];
  logic [CW-1:0]    first_code [0:MAX_LEN];
  logic [IDX_W-1:0] first_idx  [0:MAX_LEN];
  logic [CW-1:0]    code_q;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] prep_len;
  logic [CW-1:0]    off;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i <= MAX_LEN; i++) count[i] <= '0;
    end else if (cnt_we && cnt_addr != '0) begin
      count[cnt_addr] <= cnt_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || prep_init) begin
      prep_len <= LEN_W'(1);
      code_q   <= '0;
      idx_q    <= '0;
    end else if (prep_step) begin
      prep_len <= prep_len + 1'b1;
      code_q   <= (code_q + CW'(count[prep_len])) << 1;
      idx_q    <= idx_q + count[prep_len];
    end
  end

  always_ff @(posedge clk_i) begin
    if (prep_step) begin
      first_code[prep_len] <= code_q;
      first_idx[prep_len]  <= idx_q;
    end
  end

  assign prep_last = (prep_len == LEN_W'(MAX_LEN));

  // A codeword below first_code wraps to a huge offset and so never matches.
  always_comb begin
    off   = acc - first_code[len];
    match = (count[len] != '0) && (off < CW'(count[len]));
    idx   = first_idx[len] + off[IDX_W-1:0];
  end
endmodule

// File: rtl/huffman_decoder.sv
// Canonical Huffman decoder: one bit per handshake, symbol registered the cycle after its last bit;
// while a symbol waits on sym_ready_i no further bits are accepted.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int MAX_SYM   = 255,
  parameter int MAX_LEN   = HUF_MAX_LEN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cnt_we_i,
  input  logic [LEN_W-1:0]     cnt_addr_i,
  input  logic [CNT_W-1:0]     cnt_data_i,
  input  logic                 sym_we_i,
  input  logic [SYM_AW-1:0]    sym_addr_i,
  input  logic [BIT_WIDTH-1:0] sym_data_i,
  input  logic                 start_i,
  huffman_decoder_if.slave     bus,
  output logic                 done_o,
  output logic                 err_o,
  output logic [TOT_W-1:0]     total_bit
);
  huf_state_t state, state_nx;

  logic [BIT_WIDTH-1:0] sym_table [0:MAX_SYM];
  logic [MAX_LEN-1:0]   acc;
  logic [MAX_LEN:0]     acc_nx;
  logic [LEN_W-1:0]     len, len_nx;
  logic [BIT_WIDTH-1:0] sym_q;
  logic                 last_q;
  logic                 idle, restart, bit_hs, match, prep_last;
  logic [IDX_W-1:0]     idx;

  assign idle    = (state == ST_IDLE);
  assign restart = start_i && (idle || state == ST_ERROR);
  assign bit_hs  = bus.bit_valid_i && bus.bit_ready_o;
  assign acc_nx  = {acc, bus.bit_i};
  assign len_nx  = len + 1'b1;

  huffman_canon_table #(.MAX_LEN(MAX_LEN)) u_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cnt_we    (cnt_we_i && idle),
    .cnt_addr  (cnt_addr_i),
    .cnt_data  (cnt_data_i),
    .prep_init (restart),
    .prep_step (state == ST_PREP),
    .prep_last (prep_last),
    .acc       (acc_nx),
    .len       (len_nx),
    .match     (match),
    .idx       (idx)
  );

  always_ff @(posedge clk_i) begin
    if (sym_we_i && idle) sym_table[sym_addr_i] <= sym_data_i;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start_i) state_nx = ST_PREP;
      ST_PREP:   if (prep_last) state_nx = ST_DECODE;
      ST_DECODE: begin
        if (bit_hs) begin
          if (match)                                          state_nx = ST_EMIT;
          else if (bus.last_i || len_nx == LEN_W'(MAX_LEN))   state_nx = ST_ERROR;
        end
      end
      ST_EMIT:   if (bus.sym_ready_i) state_nx = last_q ? ST_DONE : ST_DECODE;
      ST_DONE:   state_nx = ST_IDLE;
      ST_ERROR:  if (start_i) state_nx = ST_PREP;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      acc       <= '0;
      len       <= '0;
      sym_q     <= '0;
      last_q    <= 1'b0;
      total_bit <= '0;
    end else begin
      state <= state_nx;
      if (restart) begin
        acc       <= '0;
        len       <= '0;
        total_bit <= '0;
      end else if (bit_hs) begin
        if (total_bit != '1) total_bit <= total_bit + 1'b1;
        if (match) begin
          sym_q  <= sym_table[SYM_AW'(idx)];
          last_q <= bus.last_i;
          acc    <= '0;
          len    <= '0;
        end else begin
          acc <= acc_nx[MAX_LEN-1:0];
          len <= len_nx;
        end
      end
    end
  end

  assign bus.bit_ready_o = (state == ST_DECODE);
  assign bus.sym_valid_o = (state == ST_EMIT);
  assign bus.sym_o       = sym_q;
  assign done_o          = (state == ST_DONE);
  assign err_o           = (state == ST_ERROR);
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder with code table A=0, B=10, C=110, D=111.
module tb_huffman_decoder;
  import huffman_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cnt_we = 1'b0;
  logic [3:0]  cnt_addr = '0;
  logic [8:0]  cnt_data = '0;
  logic        sym_we = 1'b0;
  logic [7:0]  sym_addr = '0;
  logic [7:0]  sym_data = '0;
  logic        start = 1'b0;
  logic        done, err;
  logic [10:0] total_bit;

  huffman_decoder_if #(.BIT_WIDTH(8)) bus ();

  huffman_decoder #(.BIT_WIDTH(8), .MAX_SYM(255), .MAX_LEN(15)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cnt_we_i   (cnt_we),
    .cnt_addr_i (cnt_addr),
    .cnt_data_i (cnt_data),
    .sym_we_i   (sym_we),
    .sym_addr_i (sym_addr),
    .sym_data_i (sym_data),
    .start_i    (start),
    .bus        (bus),
    .done_o     (done),
    .err_o      (err),
    .total_bit  (total_bit)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int sym_seen = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted symbol is popped and compared.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.sym_valid_o) sym_seen++;
    if (bus.sym_valid_o && bus.sym_ready_i) begin
      if (exp_q.size() == 0) check("sym_unexpected", 32'(bus.sym_o), 32'hFFFF_FFFF);
      else                   check("sym", 32'(bus.sym_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.bit_valid_i = 1'b0;
    bus.last_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_cnt(input logic [3:0] a, input logic [8:0] d);
    cnt_we = 1'b1; cnt_addr = a; cnt_data = d;
    tick();
    cnt_we = 1'b0;
  endtask

  task automatic write_sym(input logic [7:0] a, input logic [7:0] d);
    sym_we = 1'b1; sym_addr = a; sym_data = d;
    tick();
    sym_we = 1'b0;
  endtask

  task automatic load_tables();
    write_cnt(4'd1, 9'd1);
    write_cnt(4'd2, 9'd1);
    write_cnt(4'd3, 9'd2);
    for (int i = 0; i < 4; i++) write_sym(8'(i), 8'(8'h41 + i));
  endtask

  // Start, then count PREP cycles until bit_ready_o rises (expected 15).
  task automatic do_start();
    int n;
    n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    while (!bus.bit_ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("prep_latency", 32'(n), 32'd15);
    tick();
  endtask

  task automatic send_bit(input logic b, input logic l);
    int n;
    n = 0;
    bus.bit_valid_i = 1'b1; bus.bit_i = b; bus.last_i = l;
    @(negedge clk);
    while (!bus.bit_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("bit_timeout", 32'(n), 32'd0);
    tick();
    bus.bit_valid_i = 1'b0; bus.last_i = 1'b0;
  endtask

  task automatic send_stream_bcd();
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    int d0, s0;
    bus.bit_valid_i = 1'b0; bus.bit_i = 1'b0; bus.last_i = 1'b0; bus.sym_ready_i = 1'b0;

    // Basic decode with exact done timing
    do_reset();
    @(negedge clk);
    check("reset_state", 32'({bus.bit_ready_o, bus.sym_valid_o, done, err, bus.sym_o, total_bit}), 32'd0);
    tick();
    load_tables();
    do_start();
    bus.sym_ready_i = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    send_bit(1'b0, 1'b0);
    send_stream_bcd();
    @(negedge clk); check("done_t1", 32'(done), 32'd0);
    @(negedge clk); check("done_t2", 32'(done), 32'd1);
    @(negedge clk); check("done_t3", 32'(done), 32'd0);
    check("basic_total", 32'(total_bit), 32'd9);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);
    check("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    tick();

    // Backpressure: A held 5 cycles while a bit is offered
    do_reset();
    load_tables();
    do_start();
    bus.sym_ready_i = 1'b0;
    d0 = done_cnt;
    exp_q.push_back(8'h41);
    send_bit(1'b0, 1'b0);
    bus.bit_valid_i = 1'b1; bus.bit_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", 32'({bus.sym_valid_o, bus.bit_ready_o, bus.sym_o}), 32'({1'b1, 1'b0, 8'h41}));
    end
    check("bp_no_bit_taken", 32'(total_bit), 32'd1);
    tick();
    exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    bus.sym_ready_i = 1'b1;
    send_stream_bcd();
    wait_done("bp_done");
    check("bp_total", 32'(total_bit), 32'd9);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);
    check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Truncated stream 1,1(last)
    do_reset();
    load_tables();
    do_start();
    d0 = done_cnt;
    s0 = sym_seen;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    @(negedge clk); check("trunc_err", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    check("trunc_err_sticky", 32'({err, bus.bit_ready_o, bus.sym_valid_o}), 32'b100);
    check("trunc_total", 32'(total_bit), 32'd2);
    check("trunc_no_sym", 32'(sym_seen - s0), 32'd0);
    check("trunc_no_done", 32'(done_cnt - d0), 32'd0);
    tick();

    // Overlong: empty count table, fifteen 1 bits
    do_reset();
    do_start();
    s0 = sym_seen;
    for (int i = 0; i < 14; i++) send_bit(1'b1, 1'b0);
    @(negedge clk); check("ovl_14_no_err", 32'({err, bus.bit_ready_o}), 32'b01);
    tick();
    send_bit(1'b1, 1'b0);
    @(negedge clk); check("ovl_15_err", 32'(err), 32'd1);
    tick();
    check("ovl_total", 32'(total_bit), 32'd15);
    do_start();
    check("ovl_restart_clear", 32'({err, total_bit}), 32'd0);
    check("ovl_no_sym", 32'(sym_seen - s0), 32'd0);

    // Reset mid-operation after the first bit of C
    do_reset();
    load_tables();
    do_start();
    bus.sym_ready_i = 1'b1;
    exp_q.push_back(8'h41);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", 32'({bus.bit_ready_o, bus.sym_valid_o, done, err, bus.sym_o, total_bit}), 32'd0);
    rst = 1'b0;
    do_start();
    send_bit(1'b0, 1'b1);
    @(negedge clk); check("rst_counts_cleared", 32'(err), 32'd1);
    tick();
    do_reset();
    load_tables();
    do_start();
    exp_q.push_back(8'h43);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1);
    wait_done("rst_reload_done");
    check("rst_q_empty", 32'(exp_q.size()), 32'd0);

    // Count write during DECODE is ignored
    do_reset();
    load_tables();
    do_start();
    write_cnt(4'd1, 9'd0);
    exp_q.push_back(8'h41);
    send_bit(1'b0, 1'b1);
    wait_done("wr_ignored_done");
    check("wr_ignored_q_empty", 32'(exp_q.size()), 32'd0);
    check("wr_ignored_no_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end
endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Canonical Huffman decoder: the receive-side counterpart of the `huffman` encoder. It is loaded with per-length code counts and a symbol table, consumes a serial bitstream one bit per handshake, and emits one decoded `BIT_WIDTH`-bit symbol per codeword over a valid/ready port. It reports the total number of bits consumed in the same 11-bit format as the encoder's `total_bit`, so benches can cross-check encoder and decoder directly.

## Interface
- `BIT_WIDTH`, 8: symbol width.
- `MAX_SYM`, 255: highest symbol-table address; the table has `MAX_SYM+1` entries.
- `MAX_LEN`, 15: longest codeword in bits.
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `cnt_we_i` in 1: count-table write strobe.
- `cnt_addr_i` in 4: code length, 1..`MAX_LEN`; address 0 is ignored.
- `cnt_data_i` in 9: number of codes of that length.
- `sym_we_i` in 1: symbol-table write strobe.
- `sym_addr_i` in 8: canonical symbol index.
- `sym_data_i` in `BIT_WIDTH`: symbol value.
- `start_i` in 1: begin table preparation, then decoding.
- `bit_valid_i` in 1: `bit_i` is valid.
- `bit_i` in 1: next stream bit, MSB of the codeword first.
- `last_i` in 1: qualifies `bit_i` as the final bit of the stream.
- `bit_ready_o` out 1: decoder accepts a bit this cycle.
- `sym_valid_o` out 1: `sym_o` holds a decoded symbol.
- `sym_o` out `BIT_WIDTH`: decoded symbol.
- `sym_ready_i` in 1: downstream accepts `sym_o`.
- `done_o` out 1: one-cycle pulse when the stream finishes cleanly.
- `err_o` out 1: sticky; no codeword matched.
- `total_bit` out 11: bits accepted since `start_i`; saturates at 2047.

## Operation
- **States:** IDLE, PREP, DECODE, EMIT, DONE, ERROR.
- **IDLE:**
  - Table writes are accepted.
  - `start_i` moves to PREP and clears `total_bit`, the accumulator and the length counter.
  - A write in the same cycle as `start_i` still takes effect.
- **Table writes outside IDLE:** ignored.
- **PREP:** one length per cycle, L = 1..`MAX_LEN`.
  - Record `first_code[L]` = code and `first_idx[L]` = idx.
  - Then code = (code + `count[L]`) << 1 and idx = idx + `count[L]`.
  - code is `MAX_LEN+1` bits wide; idx is 9 bits wide.
  - After length `MAX_LEN`, move to DECODE.
- **DECODE:** `bit_ready_o`=1. On a bit handshake:
  - acc' = {acc, `bit_i`} and len' = len + 1.
  - `total_bit` increments, saturating at 2047.
  - Compute off = acc' − `first_code[len']`.
- **Match:** `count[len']` ≠ 0 and off < `count[len']`.
  - Register `sym_o` = `sym_table[first_idx[len'] + off]`.
  - Latch `last_i`, clear acc and len, move to EMIT.
- **No match:**
  - If `last_i` is set, or len' = `MAX_LEN`: move to ERROR.
  - Otherwise stay in DECODE.
- **EMIT:** `sym_valid_o`=1 and `bit_ready_o`=0. On `sym_ready_i`:
  - Latched last set: move to DONE.
  - Otherwise: return to DECODE.
- **DONE:** `done_o`=1 for one cycle, then IDLE.
- **ERROR:**
  - `err_o`=1; `bit_ready_o`=0 and `sym_valid_o`=0.
  - Held until `start_i`, which clears `err_o` and enters PREP with the existing tables, or until `rst_i`.
- **Reset:** clears the count table. The symbol table is not reset.

## Timing
- **Reset values:** `bit_ready_o`, `sym_valid_o`, `done_o` and `err_o` are 0; `sym_o` and `total_bit` are 0; state is IDLE.
- **`rst_i` mid-operation:** effective the next edge, from any state; no symbol or `done_o` is emitted afterwards.
- **Preparation latency:** `start_i` at cycle t gives PREP for cycles t+1 .. t+`MAX_LEN`; `bit_ready_o` first rises at t+`MAX_LEN`+1.
- **Decode latency:** `sym_valid_o` rises the cycle after the handshake of a codeword's final bit.
- **Throughput:** at best, one symbol per (L+1) cycles for a length-L code.
- **Backpressure:** while `sym_valid_o`=1 and `sym_ready_i`=0, `sym_o` is stable and no bits are accepted.
- **Input handshake:** `bit_valid_i` may toggle freely. Only cycles with `bit_valid_i` & `bit_ready_o` consume a bit, including `last_i`.
- **Done:** with `sym_ready_i`=1, `done_o` pulses two cycles after the final-bit handshake.

## Structure
- **`huffman_pkg`:** state enum, `MAX_LEN` default, count and index width constants. Shared with the encoder side.
- **Sub-module `huffman_canon_table`:**
  - Holds the count, `first_code` and `first_idx` arrays.
  - Owns the PREP iteration.
  - Provides combinational match/offset lookup for (acc', len').
- **Top level:** FSM, accumulator, symbol table and output registers.

## Test plan
All scenarios use counts[1]=1, [2]=1, [3]=2 and symbols 0x41..0x44. This gives codes A=0, B=10, C=110, D=111.
- **Basic decode:** stream 0,10,110,111 with `last_i` on the final bit and `sym_ready_i`=1. Expect `sym_o` 0x41, 0x42, 0x43, 0x44, one `done_o` pulse, and `total_bit`=9.
- **Backpressure:** hold `sym_ready_i`=0 for 5 cycles after A. Expect `sym_valid_o`=1 and `sym_o`=0x41 stable, `bit_ready_o`=0, then B, C, D decoded correctly with no bits lost.
- **Truncated stream:** bits 1,1 with `last_i` on the second. Expect `err_o`=1 sticky, no `sym_valid_o`, `total_bit`=2, no `done_o`.
- **Overlong code:** all-zero count table, 15 bits of 1. Expect `err_o` after the 15th handshake; `start_i` clears it.
- **Reset mid-operation:** `rst_i` after the first bit of 110. Expect all outputs 0 and counts cleared; after reload and `start_i`, 110 decodes to 0x43.
- **Writes outside IDLE:** a `cnt_we_i` write of count[1]=0 during DECODE is ignored; 0 still decodes to 0x41.
